hex_display_scheduler: RTL

HEX_DISPLAY_SCHEDULER -- requirements
Module: hex_display_scheduler

---
 rtl/hex_display_scheduler.sv | 130 +++++++++++++
 1 files changed

// File: rtl/hex_display_scheduler.sv
// Round-robin arbiter for three requesters that share a six-digit hex display.
// A granted owner keeps the display for a minimum dwell and can still update it after the dwell ends.
module hex_display_scheduler #(
  parameter int HOLD_CYCLES = 50000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  req,
  input  logic [71:0] value,
  input  logic [17:0] blank_in,
  output logic [2:0]  ack,
  output logic [23:0] digits,
  output logic [5:0]  blank,
  output logic [1:0]  owner,
  output logic        busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SHOW = 2'd1;
  localparam logic [1:0] OPEN = 2'd2;

  localparam logic [25:0] DWELL_LOAD = 26'(HOLD_CYCLES - 1);

  logic [1:0]  state;
  logic [1:0]  rr_ptr;
  logic [25:0] dwell;

  logic [2:0]  cand;
  logic        found;
  logic [1:0]  winner;
  logic        owner_req;
  logic        grant_en;
  logic        update_en;
  logic [1:0]  sel;
  logic [23:0] sel_value;
  logic [5:0]  sel_blank;
  logic [2:0]  sel_onehot;

  // NOTE: every signal driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    cand   = req;
    found  = 1'b0;
    winner = 2'd0;
    owner_req = 1'b0;
    case (owner)
      2'd0:    owner_req = req[0];
      2'd1:    owner_req = req[1];
      2'd2:    owner_req = req[2];
      default: owner_req = 1'b0;
    endcase
    // Once the dwell has expired, only other requesters may take the display.
    if (state == OPEN) begin
      case (owner)
        2'd0:    cand[0] = 1'b0;
        2'd1:    cand[1] = 1'b0;
        2'd2:    cand[2] = 1'b0;
        default: cand    = req;
      endcase
    end
    for (int k = 0; k < 3; k++) begin
      int idx;
      idx = (int'(rr_ptr) + k) % 3;
      if (!found && cand[idx]) begin
        found  = 1'b1;
        winner = 2'(idx);
      end
    end

    grant_en  = found && (state == IDLE || state == OPEN);
    update_en = !grant_en && (state == SHOW || state == OPEN) && owner_req;
    sel       = grant_en ? winner : owner;

    sel_value  = value[23:0];
    sel_blank  = blank_in[5:0];
    sel_onehot = 3'b001;
    case (sel)
      2'd1: begin
        sel_value  = value[47:24];
        sel_blank  = blank_in[11:6];
        sel_onehot = 3'b010;
      end
      2'd2: begin
        sel_value  = value[71:48];
        sel_blank  = blank_in[17:12];
        sel_onehot = 3'b100;
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together on the edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      rr_ptr <= 2'd0;
      dwell  <= 26'd0;
      ack    <= 3'b000;
      digits <= 24'h000000;
      blank  <= 6'b111111;
      owner  <= 2'd3;
    end else begin
      ack <= 3'b000;

      if (grant_en || update_en) begin
        digits <= sel_value;
        blank  <= sel_blank;
        ack    <= sel_onehot;
      end

      if (grant_en) begin
        owner  <= winner;
        rr_ptr <= (winner == 2'd2) ? 2'd0 : winner + 2'd1;
        dwell  <= DWELL_LOAD;
        state  <= SHOW;
      end else begin
        case (state)
          SHOW: begin
            if (dwell == 26'd0) state <= OPEN;
            else                dwell <= dwell - 26'd1;
          end
          IDLE, OPEN: ;
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign busy = (state == SHOW);

endmodule
